// File: rtl/debounce_bank.sv
// debounce_bank: N-channel synchroniser + settle-counter debouncer with rise/fall pulses
// Ports: clk, rst (async, active high), pb_raw[CHANNELS] raw inputs,
//        pb_db debounced level, pb_rise/pb_fall one-cycle edge pulses,
//        pb_long one-cycle long-press pulse (only when DEBOUNCE_LONG_PRESS_EN is defined)
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int SETTLE_CYCLES = 5,
  parameter int LONG_CYCLES   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pb_raw,
  output logic [CHANNELS-1:0] pb_db,
  output logic [CHANNELS-1:0] pb_rise,
  output logic [CHANNELS-1:0] pb_fall
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  output logic [CHANNELS-1:0] pb_long
`endif
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
`endif
  typedef enum logic {IDLE, SETTLE} state_t;
  if (CHANNELS < 1 || SETTLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_cfg
    $error("debounce_bank: all parameters must be >= 1");
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic s1, sync, db_q, rise_q, fall_q, db_d, rise_d, fall_d;
    logic [CW-1:0] cnt, cnt_d;
    state_t st, st_d;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1     <= 1'b0;
        sync   <= 1'b0;
        st     <= IDLE;
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s1     <= pb_raw[i];
        sync   <= s1;
        st     <= st_d;
        cnt    <= cnt_d;
        db_q   <= db_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end
    // A returning match while settling is a bounce and wins over acceptance.
    always_comb begin
      st_d   = st;
      cnt_d  = cnt;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (st == IDLE) begin
        st_d  = (sync != db_q) ? SETTLE : IDLE;
        cnt_d = (sync != db_q) ? CW'(1) : '0;
      end else if (sync == db_q) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (cnt == CW'(SETTLE_CYCLES)) begin
        db_d   = sync;
        rise_d = sync;
        fall_d = !sync;
        st_d   = IDLE;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
    assign pb_db[i]   = db_q;
    assign pb_rise[i] = rise_q;
    assign pb_fall[i] = fall_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
    logic [HW-1:0] hold;
    logic long_q;
    // Hold counter saturates at LONG_CYCLES so each press yields a single pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        hold   <= !db_q ? '0 : (hold == HW'(LONG_CYCLES)) ? hold : hold + 1'b1;
        long_q <= db_q && (hold == HW'(LONG_CYCLES - 1));
      end
    end
    assign pb_long[i] = long_q;
`endif
  end
endmodule
